// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display: FSM states,
// special digit codes, seven-segment patterns and conversion length.
package alu_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SHOW
    } state_t;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_E     = 4'hE;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int CONV_ITERS = 6;

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit-code to active-low seven-segment pattern.
// Codes without a glyph (B, C, D) fall through to blank.
module seg7_encode
    import alu_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (digit)
            4'd0:      seg_n = SEG_0;
            4'd1:      seg_n = SEG_1;
            4'd2:      seg_n = SEG_2;
            4'd3:      seg_n = SEG_3;
            4'd4:      seg_n = SEG_4;
            4'd5:      seg_n = SEG_5;
            4'd6:      seg_n = SEG_6;
            4'd7:      seg_n = SEG_7;
            4'd8:      seg_n = SEG_8;
            4'd9:      seg_n = SEG_9;
            DIG_MINUS: seg_n = SEG_MINUS;
            DIG_E:     seg_n = SEG_E;
            default:   seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_result_display.sv
// Captures the 6-bit ALU result, converts it to sign + two BCD digits with a
// serial double-dabble, and scans it onto a 4-digit common-anode display.
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [5:0] value_in,
    input  logic       over_in,
    output logic       busy,
    output logic       disp_valid,
    output logic [6:0] seg_n,
    output logic [3:0] an_n
);

    localparam int             CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [2:0]     ITER_LAST = 3'(CONV_ITERS - 1);

    state_t      state;
    logic [2:0]  iter;
    logic [5:0]  mag;
    logic [1:0]  tens;
    logic [3:0]  ones;
    logic        cap_sign, cap_ovf;
    logic [1:0]  disp_tens;
    logic [3:0]  disp_ones;
    logic        disp_sign, disp_ovf;

    // One double-dabble step; tens tops out at 3 so only ones is adjusted.
    logic [3:0]  ones_adj, ones_nxt;
    logic [1:0]  tens_nxt;
    logic [5:0]  mag_nxt;

    always_comb begin
        ones_adj = (ones >= 4'd5) ? ones + 4'd3 : ones;
        tens_nxt = {tens[0], ones_adj[3]};
        ones_nxt = {ones_adj[2:0], mag[5]};
        mag_nxt  = {mag[4:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            disp_valid <= 1'b0;
            iter       <= '0;
            mag        <= '0;
            tens       <= '0;
            ones       <= '0;
            cap_sign   <= 1'b0;
            cap_ovf    <= 1'b0;
            disp_tens  <= '0;
            disp_ones  <= '0;
            disp_sign  <= 1'b0;
            disp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, SHOW: begin
                    if (load) begin
                        cap_sign <= value_in[5];
                        mag      <= value_in[5] ? (~value_in + 6'd1) : value_in;
                        cap_ovf  <= over_in;
                        tens     <= '0;
                        ones     <= '0;
                        iter     <= '0;
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    tens <= tens_nxt;
                    ones <= ones_nxt;
                    mag  <= mag_nxt;
                    if (iter == ITER_LAST) begin
                        disp_tens  <= tens_nxt;
                        disp_ones  <= ones_nxt;
                        disp_sign  <= cap_sign;
                        disp_ovf   <= cap_ovf;
                        disp_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= SHOW;
                    end else begin
                        iter <= iter + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Scan: the mux looks at the next select so an_n and seg_n switch together.
    logic [CW-1:0] cnt;
    logic [1:0]    sel, sel_nxt;
    logic [3:0]    dig_mux;
    logic [6:0]    seg_nxt;

    always_comb begin
        sel_nxt = (cnt == CNT_MAX) ? sel + 2'd1 : sel;
        dig_mux = DIG_BLANK;
        if (disp_valid) begin
            case (sel_nxt)
                2'd0: dig_mux = disp_ones;
                2'd1: dig_mux = (disp_tens == 2'd0) ? DIG_BLANK : {2'b00, disp_tens};
                2'd2: dig_mux = disp_sign ? DIG_MINUS : DIG_BLANK;
                2'd3: dig_mux = disp_ovf ? DIG_E : DIG_BLANK;
                default: dig_mux = DIG_BLANK;
            endcase
        end
    end

    seg7_encode u_enc (
        .digit (dig_mux),
        .seg_n (seg_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sel   <= '0;
            an_n  <= 4'b1110;
            seg_n <= SEG_BLANK;
        end else begin
            cnt   <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            sel   <= sel_nxt;
            an_n  <= ~(4'b0001 << sel_nxt);
            seg_n <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display: expected frames are queued on load
// and compared against the scanned seven-segment output.
module tb_alu_result_display;

    localparam int DIV = 4;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [5:0] value_in;
    logic       over_in;
    logic       busy, disp_valid;
    logic [6:0] seg_n;
    logic [3:0] an_n;

    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [3:0][6:0] frame_t;   // index = digit position
    frame_t sb[$];

    alu_result_display #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value_in   (value_in),
        .over_in    (over_in),
        .busy       (busy),
        .disp_valid (disp_valid),
        .seg_n      (seg_n),
        .an_n       (an_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic frame_t model(input logic [5:0] v, input logic o);
        frame_t f;
        int sv, m;
        sv = int'($signed(v));
        m  = (sv < 0) ? -sv : sv;
        f[3] = o ? 7'b0000110 : BLANK;
        f[2] = (sv < 0) ? 7'b0111111 : BLANK;
        f[1] = (m / 10 == 0) ? BLANK : seg_of(m / 10);
        f[0] = seg_of(m % 10);
        return f;
    endfunction

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Drive a one-cycle load from a negedge; returns at the negedge after acceptance.
    task automatic start_load(input logic [5:0] v, input logic o, input bit push);
        load = 1'b1; value_in = v; over_in = o;
        if (push) sb.push_back(model(v, o));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b still high after %0d cycles, required 0", busy, k);
        end
    endtask

    // Pop one expected frame and compare a full scan of all four digits.
    task automatic drain_frame(input string tag);
        frame_t exp;
        int idx;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, required an entry", tag);
            return;
        end
        exp = sb.pop_front();
        for (int k = 0; k < 4 * DIV; k++) begin
            idx = an_idx(an_n);
            n_checks++;
            if (idx < 0) begin
                n_fail++;
                $display("FAIL %s an_onehot: an_n=%b, required one-hot low", tag, an_n);
            end else if (seg_n !== exp[idx]) begin
                n_fail++;
                $display("FAIL %s d%0d: seg_n=%b, required %b", tag, idx, seg_n, exp[idx]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; load = 1'b0; value_in = '0; over_in = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_checks += 4;
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: %b, required 0", busy); end
        if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: %b, required 0", disp_valid); end
        if (an_n !== 4'b1110)    begin n_fail++; $display("FAIL reset_an: %b, required 1110", an_n); end
        if (seg_n !== BLANK)     begin n_fail++; $display("FAIL reset_seg: %b, required %b", seg_n, BLANK); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4 * 4 * DIV / 2; n++) begin
            n_checks += 3;
            if (an_n !== ~(4'b0001 << ((n / DIV) % 4))) begin
                n_fail++;
                $display("FAIL scan_an n=%0d: an_n=%b, required %b", n, an_n, ~(4'b0001 << ((n / DIV) % 4)));
            end
            if (seg_n !== BLANK) begin
                n_fail++; $display("FAIL idle_seg n=%0d: %b, required %b", n, seg_n, BLANK);
            end
            if (busy !== 1'b0 || disp_valid !== 1'b0) begin
                n_fail++; $display("FAIL idle_flags n=%0d: busy=%b valid=%b, required 0 0", n, busy, disp_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_convert();
        logic [5:0] vals [3] = '{6'b111011, 6'b100000, 6'b011111};
        logic       ovfs [3] = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            start_load(vals[t], ovfs[t], 1'b1);
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++; $display("FAIL busy_len v=%b cyc=%0d: busy=%b, required 1", vals[t], i, busy);
                end
                @(negedge clk);
            end
            n_checks += 2;
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL busy_drop v=%b: busy=%b, required 0", vals[t], busy);
            end
            if (disp_valid !== 1'b1) begin
                n_fail++; $display("FAIL disp_valid v=%b: %b, required 1", vals[t], disp_valid);
            end
            @(negedge clk);
            drain_frame("convert");
        end
    endtask

    task automatic test_overlap();
        start_load(6'd7, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        // Lands on the third conversion edge and must be dropped.
        start_load(6'd12, 1'b0, 1'b0);
        wait_idle();
        @(negedge clk);
        drain_frame("overlap");
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL overlap_requeue: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        frame_t old_f;
        int idx;
        start_load(6'b110111, 1'b0, 1'b1);   // -9
        wait_idle();
        start_load(6'd12, 1'b0, 1'b1);
        old_f = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            idx = an_idx(an_n);
            n_checks += 2;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL b2b_busy cyc=%0d: busy=%b, required 1", i, busy);
            end
            if (idx < 0 || seg_n !== old_f[idx]) begin
                n_fail++; $display("FAIL b2b_hold cyc=%0d: an_n=%b seg_n=%b, required previous result", i, an_n, seg_n);
            end
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drop: busy=%b, required 0", busy);
        end
        @(negedge clk);
        drain_frame("back_to_back");
    endtask

    task automatic test_reset_mid_conversion();
        // Nothing is queued: this conversion is expected to be discarded.
        start_load(6'd20, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL async_busy: %b, required 0", busy); end
        if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: %b, required 0", disp_valid); end
        if (an_n !== 4'b1110)    begin n_fail++; $display("FAIL async_an: %b, required 1110", an_n); end
        if (seg_n !== BLANK)     begin n_fail++; $display("FAIL async_seg: %b, required %b", seg_n, BLANK); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4 * DIV; n++) begin
            n_checks += 3;
            if (an_n !== ~(4'b0001 << (n / DIV))) begin
                n_fail++; $display("FAIL restart_an n=%0d: %b, required %b", n, an_n, ~(4'b0001 << (n / DIV)));
            end
            if (seg_n !== BLANK) begin
                n_fail++; $display("FAIL restart_seg n=%0d: %b, required %b", n, seg_n, BLANK);
            end
            if (busy !== 1'b0 || disp_valid !== 1'b0) begin
                n_fail++; $display("FAIL restart_flags n=%0d: busy=%b valid=%b, required 0 0", n, busy, disp_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_overlap();
        test_back_to_back();
        test_reset_mid_conversion();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: %0d entries, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
